// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU in execute.
// Result goes to HI/LO as {remainder, quotient}.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      DIV_FREE,
      DIV_BY_ZERO,
      DIV_ON,
      DIV_END
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_cnt, w_cnt_nxt;
   logic [64:0] r_w, w_w_nxt;
   logic [31:0] r_d, w_d_nxt;
   logic        r_negq, w_negq_nxt;
   logic        r_negr, w_negr_nxt;
   logic [63:0] r_result, w_result_nxt;
   logic        r_ready, w_ready_nxt;

   logic        w_neg1, w_neg2, w_go;
   logic [31:0] w_mag1, w_mag2;
   logic [32:0] w_diff;
   logic [31:0] w_q, w_r;

   assign w_neg1 = signed_div_i & opdata1_i[31];
   assign w_neg2 = signed_div_i & opdata2_i[31];
   assign w_mag1 = w_neg1 ? -opdata1_i : opdata1_i;
   assign w_mag2 = w_neg2 ? -opdata2_i : opdata2_i;
   assign w_go   = start_i & ~annul_i;
   assign w_diff = {1'b0, r_w[63:32]} - {1'b0, r_d};
   assign w_q    = r_negq ? -r_w[31:0] : r_w[31:0];
   assign w_r    = r_negr ? -r_w[64:33] : r_w[64:33];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= DIV_FREE;
         r_cnt    <= '0;
         r_w      <= '0;
         r_d      <= '0;
         r_negq   <= 1'b0;
         r_negr   <= 1'b0;
         r_result <= '0;
         r_ready  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_w      <= w_w_nxt;
         r_d      <= w_d_nxt;
         r_negq   <= w_negq_nxt;
         r_negr   <= w_negr_nxt;
         r_result <= w_result_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         DIV_FREE: begin
            if (w_go)
               w_state_nxt = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
         end
         DIV_BY_ZERO: begin
            w_state_nxt = annul_i ? DIV_FREE : DIV_END;
         end
         DIV_ON: begin
            if (annul_i)
               w_state_nxt = DIV_FREE;
            else if (r_cnt == 6'd32)
               w_state_nxt = DIV_END;
         end
         DIV_END: begin
            if (!start_i)
               w_state_nxt = DIV_FREE;
         end
         default: w_state_nxt = DIV_FREE;
      endcase
   end

   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_w_nxt      = r_w;
      w_d_nxt      = r_d;
      w_negq_nxt   = r_negq;
      w_negr_nxt   = r_negr;
      w_result_nxt = r_result;
      w_ready_nxt  = r_ready;
      unique case (r_state)
         DIV_FREE: begin
            w_ready_nxt  = 1'b0;
            w_result_nxt = '0;
            if (w_go && opdata2_i != '0) begin
               w_w_nxt    = {32'b0, w_mag1, 1'b0};
               w_d_nxt    = w_mag2;
               w_negq_nxt = w_neg1 ^ w_neg2;
               w_negr_nxt = w_neg1;
               w_cnt_nxt  = '0;
            end
         end
         DIV_BY_ZERO: begin
            w_result_nxt = '0;
            w_ready_nxt  = ~annul_i;
         end
         DIV_ON: begin
            if (annul_i) begin
               w_ready_nxt  = 1'b0;
               w_result_nxt = '0;
               w_cnt_nxt    = '0;
            end else if (r_cnt != 6'd32) begin
               // diff[32] set means the trial subtraction underflowed
               if (w_diff[32])
                  w_w_nxt = {r_w[63:0], 1'b0};
               else
                  w_w_nxt = {w_diff[31:0], r_w[31:0], 1'b1};
               w_cnt_nxt = r_cnt + 6'd1;
            end else begin
               w_result_nxt = {w_r, w_q};
               w_ready_nxt  = 1'b1;
            end
         end
         DIV_END: begin
            if (!start_i) begin
               w_ready_nxt  = 1'b0;
               w_result_nxt = '0;
            end
         end
         default: begin
            w_ready_nxt  = 1'b0;
            w_result_nxt = '0;
         end
      endcase
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases
// plus randomized operations against an arithmetic model.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_chk  = 0;
   int n_pass = 0;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] ref_div(input logic s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0)
         return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = {32'b0, a};
         sb = {32'b0, b};
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_div(input string tag,
                         input logic s,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [63:0] exp,
                         input bit scr);
      int k;
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      tick();
      k = 0;
      while (!ready_o && k < 50) begin
         if (scr) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
         end
         tick();
         k++;
      end
      chk({tag, "_lat"}, 64'(k), (b == 32'd0) ? 64'd1 : 64'd33);
      chk({tag, "_res"}, result_o, exp);
      tick();
      chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
      chk({tag, "_hold_res"}, result_o, exp);
      start_i = 1'b0;
      tick();
      chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
      chk({tag, "_drop_res"}, result_o, 64'd0);
      tick();
   endtask

   initial begin
      bit seen;
      logic s;
      logic [31:0] a, b;
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (3) tick();
      chk("rst_rdy", 64'(ready_o), 64'd0);
      chk("rst_res", result_o, 64'd0);
      rst = 1'b0;
      tick();

      do_div("u100_7", 1'b0, 32'd100, 32'd7,
             64'h00000002_0000000E, 1'b0);
      do_div("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
             64'hFFFFFFFF_FFFFFFFD, 1'b0);
      do_div("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
             64'h00000001_FFFFFFFD, 1'b0);
      do_div("dz5", 1'b0, 32'd5, 32'd0, 64'd0, 1'b0);

      // annul after the tenth iteration
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      tick();
      repeat (10) tick();
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      chk("annul_rdy", 64'(ready_o), 64'd0);
      chk("annul_res", result_o, 64'd0);
      annul_i = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         tick();
         if (ready_o) seen = 1'b1;
      end
      chk("annul_idle", 64'(seen), 64'd0);
      do_div("uffff_1", 1'b0, 32'hFFFFFFFF, 32'd1,
             64'h00000000_FFFFFFFF, 1'b0);

      // synchronous reset after the twentieth iteration
      signed_div_i = 1'b0;
      opdata1_i    = 32'd12345;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      tick();
      repeat (20) tick();
      rst = 1'b1;
      tick();
      chk("midrst_rdy", 64'(ready_o), 64'd0);
      chk("midrst_res", result_o, 64'd0);
      rst     = 1'b0;
      start_i = 1'b0;
      seen    = 1'b0;
      repeat (20) begin
         tick();
         if (ready_o) seen = 1'b1;
      end
      chk("midrst_idle", 64'(seen), 64'd0);
      do_div("smin_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
             64'h00000000_80000000, 1'b0);

      // start together with annul is not taken
      opdata1_i = 32'd9;
      opdata2_i = 32'd4;
      start_i   = 1'b1;
      annul_i   = 1'b1;
      tick();
      start_i = 1'b0;
      annul_i = 1'b0;
      seen    = 1'b0;
      repeat (40) begin
         tick();
         if (ready_o) seen = 1'b1;
      end
      chk("start_annul", 64'(seen), 64'd0);

      do_div("scramble", 1'b1, 32'hFFFF0001, 32'd1000,
             ref_div(1'b1, 32'hFFFF0001, 32'd1000), 1'b1);

      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         do_div($sformatf("rnd%0d", i), s, a, b,
                ref_div(s, a, b), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
